aes_key_expander: RTL and testbench
===================================

Name: aes_key_expander

Overview:
- Sequential AES key schedule for AES-128/192/256, selected at runtime per key load. Supersedes the single-round combinational round-key generator.
- Computes one 32-bit schedule word per cycle, reusing a single SubWord unit.
- Packs every four words into a 128-bit round key. Each round key is delivered in order, 0..Nr, on a valid/ready stream to the cipher datapath or a round-key store.

Parameters:
- NK_MAX, 8, largest supported key length in 32-bit words (4, 6 or 8). Sets the key_in width and which key_len codes are legal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle load request. Accepted only in IDLE.
- key_len  in  2  sampled with start: 00=AES-128 (Nk=4, Nr=10), 01=AES-192 (Nk=6, Nr=12), 10=AES-256 (Nk=8, Nr=14), 11=reserved.
- key_in  in  32*NK_MAX  cipher key, MSB-aligned; word 0 is bits [32*NK_MAX-1 -: 32]. Unused low words are ignored.
- busy  out  1  high from accepted start until the last round key is accepted.
- key_err  out  1  one-cycle pulse when start carries an illegal key_len (11, or Nk > NK_MAX). The request is dropped.
- rk_valid  out  1  round key available.
- rk_ready  in  1  consumer accepts when rk_valid && rk_ready.
- rk_data  out  128  round key; word 4r is in bits [127:96].
- rk_round  out  4  round index r of rk_data.
- rk_last  out  1  high with rk_valid when r == Nr.

Behaviour:
- Reset (async, rst_n low): state IDLE. busy, rk_valid, rk_last and key_err = 0. rk_data, rk_round and the word window = 0. rcon = 8'h01.
- States:
  - IDLE: start with legal key_len → GEN. In that same edge: latch Nk/Nr, load the window (8x32 shift register) with key words, set word index i=0, mod-Nk counter m=0, rcon=8'h01.
  - GEN: produces word w[i] each cycle unless stalled. Words i<Nk come from the key; i≥Nk are computed.
  - DRAIN: last word produced, waiting for the final handshake → IDLE.
- Word rule, temp = w[i-1]:
  - m==0: temp' = SubWord(RotWord(temp)) ^ {rcon,24'h0}. Then rcon <= xtime(rcon) (shift left, conditional xor 8'h1b).
  - Nk==8 and m==4: temp' = SubWord(temp).
  - Otherwise temp' = temp.
  - w[i] = w[i-Nk] ^ temp'.
  - m wraps at Nk-1. No dividers: i/Nk and i mod Nk are tracked by counters only.
- Packing:
  - Words are shifted into a 4-word accumulator. On every 4th word (i mod 4 == 3), the accumulator plus the new word loads rk_data. The same edge sets rk_valid=1, rk_round=i>>2 and rk_last=(i>>2==Nr).
  - Total words = 4*(Nr+1): 44/52/60.
- Latency: first rk_valid 4 cycles after the start edge. With rk_ready held high, one round key every 4 cycles. AES-128 completes in 44 cycles after start.
- Backpressure: if rk_valid && !rk_ready when word generation would overwrite rk_data (i mod 4 == 3), GEN stalls. i, m, rcon and the window are held. rk_data and rk_round stay stable while rk_valid is high. Words i mod 4 ∈ {0,1,2} may proceed during a stall.
- Simultaneous accept and load: if the final accept and a new rk_data load coincide, the new data is loaded and rk_valid stays 1.
- Completion: on acceptance of the rk_last beat, go to IDLE with busy=0. start in that same cycle is ignored; the earliest new start is one cycle later.
- start while busy: ignored, no key_err. key_in and key_len may change freely after acceptance.
- Reset mid-operation: immediate return to reset values. No partial key is emitted afterwards.

Decomposition:
- Package aes_pkg: key_len encodings, Nk/Nr lookup constants, state enum, xtime function, AES S-box table.
- Sub-module aes_subword: 32-bit combinational SubWord of four S-box lookups. It is the only instance in this block.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → r0 = key; r1 = a0fafe1788542cb123a339392a6c7605; r10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last. 11 beats, 4 cycles apart.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b (MSB-aligned, low 64 bits zero) → r12 = e98ba06f448c773c8ecc720401002202. 13 beats.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → r1 = 1f352c073b6108d72d9810a30914dff4; r14 = fe4890d1e6188d0b046df344706c631e. 15 beats.
- AES-128 with random rk_ready stalls (up to 10 cycles) → rk_data/rk_round stable while rk_valid && !rk_ready. Same 11 keys as the no-stall run. No beat lost or duplicated.
- start with key_len=11; then start pulsed while busy → key_err pulse and no rk_valid for the first. Second start ignored, no key_err, in-flight sequence unaffected.
- rst_n asserted after round 5 of AES-256, then new AES-128 start → outputs clear asynchronously. Sequence restarts at r0 with rcon=01 and correct r1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key length codes, Nk/Nr lookup,
// FSM state type, GF(2^8) xtime and the forward S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128  = 2'b00,
    KL_192  = 2'b01,
    KL_256  = 2'b10,
    KL_RSVD = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Key length in 32-bit words; 0 marks the reserved code.
  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_128:  nk_of = 4'd4;
      KL_192:  nk_of = 4'd6;
      KL_256:  nk_of = 4'd8;
      default: nk_of = 4'd0;
    endcase
  endfunction

  // Number of cipher rounds.
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_128:  nr_of = 4'd10;
      KL_192:  nr_of = 4'd12;
      KL_256:  nr_of = 4'd14;
      default: nr_of = 4'd0;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Index 0 is the leftmost byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX[b];
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Load request and round-key stream between the key expander and its user.
interface aes_key_expander_if #(parameter int NK_MAX = 8);
  logic                  start;
  logic [1:0]            key_len;
  logic [32*NK_MAX-1:0]  key_in;
  logic                  busy;
  logic                  key_err;
  logic                  rk_valid;
  logic                  rk_ready;
  logic [127:0]          rk_data;
  logic [3:0]            rk_round;
  logic                  rk_last;

  modport master (
    output start, key_len, key_in, rk_ready,
    input  busy, key_err, rk_valid, rk_data, rk_round, rk_last
  );

  modport slave (
    input  start, key_len, key_in, rk_ready,
    output busy, key_err, rk_valid, rk_data, rk_round, rk_last
  );
endinterface

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);
  // Byte-wise substitution, byte order preserved.
  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};
endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule, one word per cycle, emitting
// 128-bit round keys 0..Nr on a valid/ready stream.
//
// state    | meaning
// ST_IDLE  | waiting for start; load window on a legal request
// ST_GEN   | producing w[i] each cycle unless the output register is full
// ST_DRAIN | last round key presented, waiting for its acceptance
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NK_MAX = 8
) (
  input logic              clk,
  input logic              rst_n,
  aes_key_expander_if.slave bus
);

  state_e        state;
  logic [31:0]   win [8];      // win[0] = w[i-Nk], win[Nk-1] = w[i-1]
  logic [5:0]    idx;
  logic [2:0]    m;
  logic [7:0]    rcon;
  logic [3:0]    nk;
  logic [5:0]    last_idx;
  logic [95:0]   acc;
  logic          busy_q, key_err_q, rk_valid_q, rk_last_q;
  logic [127:0]  rk_data_q;
  logic [3:0]    rk_round_q;

  logic [255:0]  key_pad;
  logic [2:0]    top_sel;
  logic [31:0]   temp, sub_in, sub_out, temp_x, new_word;
  logic          key_phase, stall, advance, accept, kl_legal;

  assign key_pad   = 256'(bus.key_in) << (256 - 32*NK_MAX);
  assign top_sel   = 3'(nk - 4'd1);
  assign temp      = win[top_sel];
  assign sub_in    = (m == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
  assign key_phase = idx < {2'b00, nk};
  assign stall     = rk_valid_q && !bus.rk_ready && (idx[1:0] == 2'b11);
  assign advance   = (state == ST_GEN) && !stall;
  assign accept    = rk_valid_q && bus.rk_ready;
  assign kl_legal  = (bus.key_len != KL_RSVD) && (int'(nk_of(bus.key_len)) <= NK_MAX);

  aes_subword u_subword (.word_in(sub_in), .word_out(sub_out));

  // Select the transformed w[i-1] and form the next schedule word.
  always_comb begin
    temp_x = temp;
    if (m == 3'd0)
      temp_x = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && m == 3'd4)
      temp_x = sub_out;
    new_word = key_phase ? win[0] : (win[0] ^ temp_x);
  end

  // Control FSM, schedule window, packing and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy_q     <= 1'b0;
      key_err_q  <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      rk_data_q  <= '0;
      rk_round_q <= '0;
      rcon       <= 8'h01;
      idx        <= '0;
      m          <= '0;
      nk         <= '0;
      last_idx   <= '0;
      acc        <= '0;
      for (int k = 0; k < 8; k++) win[k] <= '0;
    end else begin
      key_err_q <= 1'b0;
      if (accept) begin
        rk_valid_q <= 1'b0;
        rk_last_q  <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (kl_legal) begin
              state    <= ST_GEN;
              busy_q   <= 1'b1;
              nk       <= nk_of(bus.key_len);
              last_idx <= {nr_of(bus.key_len), 2'b11};
              idx      <= '0;
              m        <= '0;
              rcon     <= 8'h01;
              for (int k = 0; k < 8; k++) win[k] <= key_pad[255-32*k -: 32];
            end else begin
              key_err_q <= 1'b1;
            end
          end
        end
        ST_GEN: begin
          if (advance) begin
            for (int k = 0; k < 7; k++) win[k] <= win[k+1];
            win[top_sel] <= new_word;
            idx <= idx + 6'd1;
            m   <= ({1'b0, m} == nk - 4'd1) ? 3'd0 : m + 3'd1;
            if (!key_phase && m == 3'd0) rcon <= xtime(rcon);
            if (idx[1:0] != 2'b11) begin
              acc <= {acc[63:0], new_word};
            end else begin
              rk_data_q  <= {acc, new_word};
              rk_valid_q <= 1'b1;
              rk_round_q <= idx[5:2];
              rk_last_q  <= (idx == last_idx);
            end
            if (idx == last_idx) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (accept) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.key_err  = key_err_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_data  = rk_data_q;
  assign bus.rk_round = rk_round_q;
  assign bus.rk_last  = rk_last_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander using FIPS-197 key schedule vectors.
module tb_aes_key_expander;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_expander_if #(.NK_MAX(8)) bus ();
  aes_key_expander #(.NK_MAX(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [127:0] data;
    logic         chk;
    logic [3:0]   round;
    logic         last;
    longint       cyc;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  int     pops = 0;
  longint cyc = 0;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [127:0] rk128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: pop expected beat on each handshake, and check stability during stalls.
  logic         hold_v = 1'b0;
  logic [127:0] hold_d;
  logic [3:0]   hold_r;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_valid", 128'(bus.rk_valid), 128'(1'b1));
        check("stall_data", bus.rk_data, hold_d);
        check("stall_round", 128'(bus.rk_round), 128'(hold_r));
      end
      if (bus.rk_valid && bus.rk_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got round %0d want no beat", bus.rk_round);
        end else begin
          e = sb.pop_front();
          pops++;
          if (e.chk) check($sformatf("rk_data_r%0d", e.round), bus.rk_data, e.data);
          check("rk_round", 128'(bus.rk_round), 128'(e.round));
          check($sformatf("rk_last_r%0d", e.round), 128'(bus.rk_last), 128'(e.last));
          if (e.cyc >= 0) check($sformatf("beat_cycle_r%0d", e.round), 128'(cyc), 128'(e.cyc));
        end
      end
      hold_v = bus.rk_valid && !bus.rk_ready;
      hold_d = bus.rk_data;
      hold_r = bus.rk_round;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_key(input logic [1:0] kl, input logic [255:0] key, output longint c0);
    bus.key_len = kl;
    bus.key_in  = key;
    bus.start   = 1'b1;
    tick();
    c0 = cyc;
    bus.start = 1'b0;
  endtask

  // kind: 0 = AES-128 (full table), 1 = AES-192, 2 = AES-256
  task automatic push_seq(input int kind, input longint c0, input bit timed);
    int nr;
    exp_t e;
    nr = (kind == 0) ? 10 : (kind == 1) ? 12 : 14;
    for (int r = 0; r <= nr; r++) begin
      e.round = 4'(r);
      e.last  = (r == nr);
      e.cyc   = timed ? c0 + 4 + 4*r : -1;
      e.chk   = 1'b0;
      e.data  = '0;
      if (kind == 0) begin
        e.chk = 1'b1; e.data = rk128[r];
      end else if (kind == 1) begin
        if (r == 0)  begin e.chk = 1'b1; e.data = KEY192[255:128]; end
        if (r == 12) begin e.chk = 1'b1; e.data = 128'he98ba06f448c773c8ecc720401002202; end
      end else begin
        if (r == 0)  begin e.chk = 1'b1; e.data = KEY256[255:128]; end
        if (r == 1)  begin e.chk = 1'b1; e.data = KEY256[127:0]; end
        if (r == 14) begin e.chk = 1'b1; e.data = 128'hfe4890d1e6188d0b046df344706c631e; end
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 400) begin
      tick();
      n++;
    end
    check({name, "_done"}, 128'(sb.size() == 0 && !bus.busy), 128'(1'b1));
  endtask

  initial begin
    longint c0;
    int n;
    logic seen;
    bus.start = 1'b0; bus.key_len = 2'b00; bus.key_in = '0; bus.rk_ready = 1'b1;
    #2;
    check("rst_busy", 128'(bus.busy), 128'(1'b0));
    check("rst_valid", 128'(bus.rk_valid), 128'(1'b0));
    check("rst_last", 128'(bus.rk_last), 128'(1'b0));
    check("rst_err", 128'(bus.key_err), 128'(1'b0));
    check("rst_data", bus.rk_data, 128'h0);
    check("rst_round", 128'(bus.rk_round), 128'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // AES-128, no backpressure, exact beat timing
    start_key(2'b00, KEY128, c0);
    push_seq(0, c0, 1'b1);
    check("busy_after_start", 128'(bus.busy), 128'(1'b1));
    wait_done("aes128");
    tick();

    // AES-192
    start_key(2'b01, KEY192, c0);
    push_seq(1, c0, 1'b1);
    wait_done("aes192");
    tick();

    // AES-256
    start_key(2'b10, KEY256, c0);
    push_seq(2, c0, 1'b1);
    wait_done("aes256");
    tick();

    // AES-128 with random backpressure
    bus.rk_ready = 1'b0;
    start_key(2'b00, KEY128, c0);
    push_seq(0, c0, 1'b0);
    for (int b = 0; b < 11; b++) begin
      n = 0;
      while (!bus.rk_valid && n < 40) begin tick(); n++; end
      check("stall_wait_valid", 128'(bus.rk_valid), 128'(1'b1));
      repeat ($urandom_range(10, 0)) tick();
      bus.rk_ready = 1'b1;
      tick();
      bus.rk_ready = 1'b0;
    end
    bus.rk_ready = 1'b1;
    wait_done("aes128_stall");
    tick();

    // Reserved key length
    start_key(2'b11, KEY128, c0);
    check("key_err_pulse", 128'(bus.key_err), 128'(1'b1));
    check("key_err_busy", 128'(bus.busy), 128'(1'b0));
    tick();
    check("key_err_clear", 128'(bus.key_err), 128'(1'b0));
    seen = 1'b0;
    repeat (6) begin tick(); seen = seen | bus.rk_valid; end
    check("key_err_no_valid", 128'(seen), 128'(1'b0));

    // start while busy is ignored
    start_key(2'b00, KEY128, c0);
    push_seq(0, c0, 1'b1);
    repeat (8) tick();
    bus.key_len = 2'b10; bus.key_in = KEY256; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_start_no_err", 128'(bus.key_err), 128'(1'b0));
    check("busy_start_busy", 128'(bus.busy), 128'(1'b1));
    wait_done("aes128_busy_start");
    tick();

    // Reset after round 5 of AES-256, then fresh AES-128
    start_key(2'b10, KEY256, c0);
    push_seq(2, c0, 1'b0);
    n = pops + 6;
    c0 = 0;
    while (pops < n && c0 < 200) begin tick(); c0++; end
    check("pre_reset_pops", 128'(pops), 128'(n));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 128'(bus.busy), 128'(1'b0));
    check("mid_rst_valid", 128'(bus.rk_valid), 128'(1'b0));
    check("mid_rst_data", bus.rk_data, 128'h0);
    check("mid_rst_round", 128'(bus.rk_round), 128'h0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    start_key(2'b00, KEY128, c0);
    push_seq(0, c0, 1'b1);
    wait_done("aes128_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
